dm_chunk_cmd_gen: RTL

//  Splits one register-programmed transfer (base address, total bytes) into CHUNK_BYTES commands
//  for one AXI DataMover channel (MM2S or S2MM; one instance per channel), sits between the
//  AXI-Lite control block and the DataMover CMD/STS ports. Tracks outstanding commands, consumes
//  8-bit status beats, reports busy/done/error and per-transfer counters.

---
 rtl/dm_chunk_cmd_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dm_chunk_cmd_gen.sv
// Chunked AXI DataMover command generator with outstanding-command tracking and status checking.
// Optional feature: define DM_CMD_GEN_4K_SPLIT_EN to keep every command inside one 4 KiB page.
module dm_chunk_cmd_gen #(
  parameter int CHUNK_BYTES     = 1024,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 32
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  total_len,
  output logic [71:0]       m_cmd_tdata,
  output logic              m_cmd_tvalid,
  input  logic              m_cmd_tready,
  input  logic [7:0]        s_sts_tdata,
  input  logic              s_sts_tvalid,
  output logic              s_sts_tready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       chunks_issued,
  output logic [15:0]       chunks_retired
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [3:0]        outstanding;
  logic [3:0]        out_next;
  logic              cmd_hs;
  logic              sts_beat;
  logic              sts_count;
  logic              sts_bad;
  logic [15:0]       idx_next;
  logic [LEN_W-1:0]  room_cur;
  logic [LEN_W-1:0]  room_base;
  logic [LEN_W-1:0]  btt_cur;
  logic [LEN_W-1:0]  btt_base;

  function automatic logic [LEN_W-1:0] chunk_len(input logic [LEN_W-1:0] rem,
                                                 input logic [LEN_W-1:0] room);
    logic [LEN_W-1:0] n;
    n = LEN_W'(CHUNK_BYTES);
    if (rem < n) n = rem;
    if (room < n) n = room;
    return n;
  endfunction

  function automatic logic [71:0] cmd_word(input logic [3:0] tag, input logic [ADDR_W-1:0] a,
                                           input logic [LEN_W-1:0] btt, input logic eof);
    return {4'h0, tag, 32'(a), 1'b0, eof, 6'h00, 1'b1, 23'(btt)};
  endfunction

`ifdef DM_CMD_GEN_4K_SPLIT_EN
  assign room_cur  = LEN_W'(13'h1000 - {1'b0, addr[11:0]});
  assign room_base = LEN_W'(13'h1000 - {1'b0, base_addr[11:0]});
`else
  assign room_cur  = LEN_W'(CHUNK_BYTES);
  assign room_base = LEN_W'(CHUNK_BYTES);
`endif

  assign btt_cur   = chunk_len(remaining, room_cur);
  assign btt_base  = chunk_len(total_len, room_base);
  assign cmd_hs    = m_cmd_tvalid & m_cmd_tready;
  assign sts_beat  = s_sts_tvalid & s_sts_tready;
  // A status only retires a command when one is actually outstanding; anything else is stray.
  assign sts_count = sts_beat && (state != IDLE) && (outstanding != 4'd0);
  assign sts_bad   = !s_sts_tdata[7] || (|s_sts_tdata[6:4]) ||
                     (s_sts_tdata[3:0] != chunks_retired[3:0]);
  assign out_next  = outstanding + {3'b000, cmd_hs} - {3'b000, sts_count};
  assign idx_next  = cmd_hs ? chunks_issued + 16'd1 : chunks_issued;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      outstanding    <= 4'd0;
      m_cmd_tdata    <= 72'd0;
      m_cmd_tvalid   <= 1'b0;
      s_sts_tready   <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      chunks_issued  <= 16'd0;
      chunks_retired <= 16'd0;
    end else begin
      done         <= 1'b0;
      s_sts_tready <= 1'b1;
      outstanding  <= out_next;
      if (cmd_hs) chunks_issued <= chunks_issued + 16'd1;
      if (sts_count) begin
        chunks_retired <= chunks_retired + 16'd1;
        if (sts_bad) err <= 1'b1;
      end else if (sts_beat) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            err            <= 1'b0;
            chunks_issued  <= 16'd0;
            chunks_retired <= 16'd0;
            outstanding    <= 4'd0;
            if (total_len != '0) begin
              m_cmd_tvalid <= 1'b1;
              m_cmd_tdata  <= cmd_word(4'h0, base_addr, btt_base, btt_base == total_len);
              addr         <= base_addr + ADDR_W'(btt_base);
              remaining    <= total_len - btt_base;
              state        <= ISSUE;
            end else begin
              state <= FINISH;
            end
          end
        end
        ISSUE: begin
          // addr/remaining always describe the chunk after the one currently presented.
          if (cmd_hs && m_cmd_tdata[30]) begin
            m_cmd_tvalid <= 1'b0;
            state        <= DRAIN;
          end else if ((cmd_hs || !m_cmd_tvalid) && (out_next < MAX_OUT)) begin
            m_cmd_tvalid <= 1'b1;
            m_cmd_tdata  <= cmd_word(idx_next[3:0], addr, btt_cur, btt_cur == remaining);
            addr         <= addr + ADDR_W'(btt_cur);
            remaining    <= remaining - btt_cur;
          end else if (cmd_hs) begin
            m_cmd_tvalid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_next == 4'd0) state <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
